// File: rtl/sample_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : sample_delay_line
// Description : RAM-based sample delay line. Every accepted input sample
//               reappears on the output exactly 2^DELAY_SHIFT accepted
//               samples later. The delay is counted in accepted samples, not
//               clock cycles, so gaps in the valid strobe do not change it.
//               Storage is a circular buffer: one simple-dual-port memory
//               addressed by a single read-before-write pointer.
//
// Parameters  : WIDTH       - sample width in bits (default 32)
//               DELAY_SHIFT - log2 of the delay depth, legal range 1..12
//                             (default 9, i.e. 512 samples)
//
// Ports       : clock    in   single clock, rising-edge active
//               reset    in   asynchronous active-low reset
//               enable   in   block enable; low = inputs ignored, state held
//               ivalid   in   input sample strobe
//               shiftin  in   input sample [WIDTH-1:0]
//               ovalid   out  output sample strobe (registered)
//               shiftout out  delayed sample [WIDTH-1:0] (registered)
//
// Build option: SAMPLE_DELAY_PASS_UNPRIMED_EN
//               When defined, ovalid pulses after every accepted sample,
//               including the first DEPTH samples, for which shiftout is
//               forced to zero (zero-prefilled line). When undefined, ovalid
//               stays low until the line has been primed with DEPTH samples.
//
// Revision    : 1.0 - initial release
// ============================================================================
module sample_delay_line #(
    parameter int WIDTH       = 32,
    parameter int DELAY_SHIFT = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             ivalid,
    input  logic [WIDTH-1:0] shiftin,
    output logic             ovalid,
    output logic [WIDTH-1:0] shiftout
);

    localparam int                   c_DEPTH = 1 << DELAY_SHIFT;
    localparam logic [DELAY_SHIFT:0] c_FULL  = (DELAY_SHIFT + 1)'(c_DEPTH);

    // Reject out-of-range depths at elaboration time.
    if ((DELAY_SHIFT < 1) || (DELAY_SHIFT > 12)) begin : g_bad_delay_shift
        $error("sample_delay_line: DELAY_SHIFT must be in 1..12");
    end

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]       r_mem [c_DEPTH];
    logic [DELAY_SHIFT-1:0] r_wr_ptr;
    logic [DELAY_SHIFT:0]   r_fill;
    logic                   r_ovalid;
    logic [WIDTH-1:0]       r_shiftout;

    logic                   w_accept;
    logic                   w_primed;
    logic [WIDTH-1:0]       w_rd_data;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    assign w_accept  = enable & ivalid;
    assign w_primed  = (r_fill == c_FULL);

    // The slot about to be overwritten holds the sample accepted exactly
    // DEPTH accepts ago. Reading it combinationally from the current pointer
    // gives read-before-write semantics on a same-address collision: the old
    // contents are captured on the same edge that stores shiftin.
    assign w_rd_data = r_mem[r_wr_ptr];

    // ------------------------------------------------------------------------
    // Sample memory (no reset: contents are never exposed before priming)
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= shiftin;
        end
    end

    // ------------------------------------------------------------------------
    // Pointer and fill counter
    // ------------------------------------------------------------------------
    // The pointer is exactly DELAY_SHIFT bits wide, so DEPTH-1 -> 0 wraps by
    // natural overflow with no extra cycle. The fill counter is one bit
    // wider so it can hold DEPTH itself, where it saturates.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_fill   <= '0;
        end else if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (!w_primed) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------------
    // ovalid is a single-cycle pulse per qualifying accept; shiftout only
    // changes on a qualifying accept and otherwise holds its last value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ovalid   <= 1'b0;
            r_shiftout <= '0;
        end else begin
`ifdef SAMPLE_DELAY_PASS_UNPRIMED_EN
            r_ovalid <= w_accept;
            if (w_accept) begin
                // Until primed the memory holds stale or undefined data;
                // emulate a zero-prefilled line instead.
                r_shiftout <= w_primed ? w_rd_data : '0;
            end
`else
            r_ovalid <= w_accept & w_primed;
            if (w_accept && w_primed) begin
                r_shiftout <= w_rd_data;
            end
`endif
        end
    end

    assign ovalid   = r_ovalid;
    assign shiftout = r_shiftout;

endmodule
`default_nettype wire

// File: tb/tb_sample_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_delay_line
// Description : Self-checking bench for sample_delay_line. Three instances
//               (DELAY_SHIFT = 9, 2, 1) share one stimulus stream; each is
//               compared every cycle against a FIFO-based reference model
//               that holds the last DEPTH accepted samples.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_delay_line;

    localparam int WIDTH = 32;
`ifdef SAMPLE_DELAY_PASS_UNPRIMED_EN
    localparam bit PASS_UNPRIMED = 1'b1;
`else
    localparam bit PASS_UNPRIMED = 1'b0;
`endif

    logic             clock;
    logic             reset;
    logic             enable;
    logic             ivalid;
    logic [WIDTH-1:0] shiftin;

    int n_vec;
    int n_err;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ------------------------------------------------------------------------
    // DUT instances plus one reference model per instance
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DS    = (g == 0) ? 9 : ((g == 1) ? 2 : 1);
        localparam int DEPTH = 1 << DS;

        logic             ov;
        logic [WIDTH-1:0] so;
        logic             exp_ov;
        logic [WIDTH-1:0] exp_so;
        logic [WIDTH-1:0] q [$];

        sample_delay_line #(
            .WIDTH       (WIDTH),
            .DELAY_SHIFT (DS)
        ) u_dut (
            .clock    (clock),
            .reset    (reset),
            .enable   (enable),
            .ivalid   (ivalid),
            .shiftin  (shiftin),
            .ovalid   (ov),
            .shiftout (so)
        );

        // Reference: a FIFO of the most recent accepted samples. Once it
        // holds DEPTH entries, each new accept pops the sample from DEPTH
        // accepts ago.
        always @(posedge clock or negedge reset) begin
            if (!reset) begin
                q.delete();
                exp_ov <= 1'b0;
                exp_so <= '0;
            end else if (enable && ivalid) begin
                if (q.size() == DEPTH) begin
                    exp_ov <= 1'b1;
                    exp_so <= q[0];
                    void'(q.pop_front());
                end else begin
                    exp_ov <= PASS_UNPRIMED;
                    exp_so <= '0;
                end
                q.push_back(shiftin);
            end else begin
                exp_ov <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic check_all();
        check("ovalid_ds9",   {31'd0, g_dut[0].ov}, {31'd0, g_dut[0].exp_ov});
        check("shiftout_ds9", g_dut[0].so,          g_dut[0].exp_so);
        check("ovalid_ds2",   {31'd0, g_dut[1].ov}, {31'd0, g_dut[1].exp_ov});
        check("shiftout_ds2", g_dut[1].so,          g_dut[1].exp_so);
        check("ovalid_ds1",   {31'd0, g_dut[2].ov}, {31'd0, g_dut[2].exp_ov});
        check("shiftout_ds1", g_dut[2].so,          g_dut[2].exp_so);
    endtask

    // Drive one cycle of inputs, let the edge happen, then sample outputs.
    task automatic step(input logic en, input logic iv, input logic [WIDTH-1:0] d);
        enable  = en;
        ivalid  = iv;
        shiftin = d;
        @(posedge clock);
        #1;
        check_all();
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        logic [WIDTH-1:0] cnt;
        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b0;
        enable  = 1'b0;
        ivalid  = 1'b0;
        shiftin = '0;

        // Reset state
        #51;
        check("rst_ovalid",   {31'd0, g_dut[0].ov}, 32'd0);
        check("rst_shiftout", g_dut[0].so,          32'd0);
        reset = 1'b1;

        // Continuous fill with counter 1,2,3,...: the DS=9 line primes after
        // 512 accepts, DS=2/DS=1 lines wrap their pointers many times.
        cnt = 32'd1;
        for (int i = 0; i < 600; i++) begin
            step(1'b1, 1'b1, cnt);
            if (i == 512) begin
                check("first_out_ds9", g_dut[0].so, 32'd1);
            end
            cnt++;
        end

        // Gapped input: valid on alternate cycles
        for (int i = 0; i < 40; i++) begin
            step(1'b1, i[0], cnt);
            if (i[0]) cnt++;
        end

        // Enable gating with ivalid held high
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, $urandom);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, cnt);
            cnt++;
        end

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1, $urandom);
        end

        // Mid-stream reset: outputs must clear before the next edge
        step(1'b1, 1'b1, $urandom);
        #2;
        reset = 1'b0;
        #1;
        check("async_ovalid",   {31'd0, g_dut[1].ov}, 32'd0);
        check("async_shiftout", g_dut[1].so,          32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, $urandom);
        end
        reset = 1'b1;

        // Re-prime with random data, stale memory must never appear
        for (int i = 0; i < 600; i++) begin
            step(1'b1, ($urandom_range(0, 3) != 0), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
